// File: rtl/bnn_pkg.sv
// Shared types and defaults for the BNN layer sequencing logic.
package bnn_pkg;

  localparam int SEQ_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ERROR = 3'd4
  } seq_state_t;

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer cycle counter; expired flags that the active layer has used its whole budget.
module layer_watchdog
  import bnn_pkg::*;
#(
  parameter int TIMEOUT = SEQ_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  // The count parks at LAST, so it cannot wrap even if tick stays high.
  assign expired = (count == LAST);

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs a chain of Conv2d layers in order, holding results until acknowledged,
// with a per-layer watchdog that parks the sequencer in ERROR on a stall.
module conv_layer_sequencer
  import bnn_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int TIMEOUT    = SEQ_TIMEOUT,
  parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic [IDX_W-1:0]      layer_idx,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic                  error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

  seq_state_t       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             done_cur;
  logic             wd_clear;
  logic             wd_tick;
  logic             wd_expired;

  // Only the running layer's done is observed; all other bits are don't-care.
  always_comb begin
    done_cur = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (IDX_W'(i) == idx) done_cur = layer_done[i];
    end
  end

  assign wd_tick  = (state == ST_RUN);
  assign wd_clear = abort || (state != ST_RUN) || done_cur;

  layer_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .tick   (wd_tick),
    .expired(wd_expired)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    if (abort) begin
      state_n = ST_IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx_n = '0;
          if (start) state_n = ST_CLEAR;
        end
        ST_CLEAR: begin
          state_n = ST_RUN;
          idx_n   = '0;
        end
        ST_RUN: begin
          if (done_cur) begin
            if (idx == LAST_IDX) state_n = ST_HOLD;
            else                 idx_n   = idx + IDX_W'(1);
          end else if (wd_expired) begin
            state_n = ST_ERROR;
          end
        end
        ST_HOLD: begin
          if (result_ack) begin
            state_n = ST_IDLE;
            idx_n   = '0;
          end
        end
        ST_ERROR: begin
          if (start) begin
            state_n = ST_CLEAR;
            idx_n   = '0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Enables are cumulative: upstream layers stay enabled so their outputs remain valid.
  always_comb begin
    layer_en = '0;
    if (state == ST_RUN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        layer_en[i] = (IDX_W'(i) <= idx);
      end
    end else if (state == ST_HOLD) begin
      layer_en = '1;
    end
  end

  assign layer_idx    = idx;
  assign busy         = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_HOLD);
  assign result_valid = (state == ST_HOLD);
  // The error flag lives in the ERROR state itself, so leaving ERROR clears it.
  assign error        = (state == ST_ERROR);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scenario bench for conv_layer_sequencer with behavioural Conv2d done models.
module tb_conv_layer_sequencer;

  localparam int NL = 3;
  localparam int TO = 16;

  typedef struct packed {
    logic [2:0] en;
    logic [1:0] idx;
    logic       busy;
    logic       valid;
    logic       err;
  } obs_t;

  typedef struct {
    logic start;
    logic abort;
    logic ack;
    obs_t val;
    obs_t mask;
  } step_t;

  localparam obs_t S_IDLE  = 8'b000_00_000;
  localparam obs_t S_CLR   = 8'b000_00_100;
  localparam obs_t S_R0    = 8'b001_00_100;
  localparam obs_t S_R1    = 8'b011_01_100;
  localparam obs_t S_R2    = 8'b111_10_100;
  localparam obs_t S_HOLD  = 8'b111_00_110;
  localparam obs_t S_ERR   = 8'b000_00_001;
  localparam obs_t M_ALL   = 8'b111_11_111;
  localparam obs_t M_NOIDX = 8'b111_00_111;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          result_ack;
  logic [NL-1:0] layer_done;
  logic [NL-1:0] layer_en;
  logic [1:0]    layer_idx;
  logic          busy;
  logic          result_valid;
  logic          error;

  int    n_run  = 0;
  int    n_fail = 0;
  int    lat[NL];
  int    cnt[NL];
  bit    model_on = 1'b1;
  step_t sb[$];

  conv_layer_sequencer #(
    .NUM_LAYERS(NL),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .layer_done  (layer_done),
    .layer_en    (layer_en),
    .layer_idx   (layer_idx),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ack  (result_ack),
    .error       (error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  function automatic obs_t sample();
    return {layer_en, layer_idx, busy, result_valid, error};
  endfunction

  function automatic void push(logic s, logic a, logic k, obs_t v, obs_t m, int n);
    step_t e;
    e.start = s; e.abort = a; e.ack = k; e.val = v; e.mask = m;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endfunction

  function automatic void push_run(int l0, int l1, int l2);
    push(1'b1, 1'b0, 1'b0, S_CLR, M_ALL, 1);
    push(1'b0, 1'b0, 1'b0, S_R0,  M_ALL, l0);
    push(1'b0, 1'b0, 1'b0, S_R1,  M_ALL, l1);
    push(1'b0, 1'b0, 1'b0, S_R2,  M_ALL, l2);
  endfunction

  // Conv2d model: done rises once enable has been seen high for lat[i] cycles.
  task automatic cycle();
    if (model_on)
      for (int i = 0; i < NL; i++) layer_done[i] = layer_en[i] && (cnt[i] >= lat[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) cnt[i] = layer_en[i] ? cnt[i] + 1 : 0;
  endtask

  task automatic test_reset();
    #1;
    n_run++;
    if (sample() !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_async: dut=%b expected=%b", sample(), S_IDLE);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    n_run++;
    if (sample() !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_release: dut=%b expected=%b", sample(), S_IDLE);
    end
  endtask

  task automatic test_nominal();
    step_t e;
    int    step = 0;
    lat = '{4, 8, 2};
    push_run(4, 8, 2);
    push(1'b0, 1'b0, 1'b0, S_HOLD, M_NOIDX, 3);
    push(1'b0, 1'b0, 1'b1, S_IDLE, M_ALL, 1);
    push(1'b0, 1'b0, 1'b0, S_IDLE, M_ALL, 1);
    while (sb.size() != 0) begin
      start = sb[0].start; abort = sb[0].abort; result_ack = sb[0].ack;
      cycle();
      e = sb.pop_front();
      n_run++;
      if ((sample() & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL nominal step %0d: dut=%b expected=%b", step, sample(), e.val);
      end
      step++;
    end
  endtask

  task automatic test_timeout();
    step_t e;
    int    step = 0;
    lat = '{3, 1000, 2};
    push_run(3, TO, 0);
    push(1'b0, 1'b0, 1'b0, S_ERR, M_NOIDX, 3);
    push(1'b1, 1'b0, 1'b0, S_CLR, M_ALL, 1);
    push(1'b0, 1'b0, 1'b0, S_R0,  M_ALL, 1);
    push(1'b0, 1'b1, 1'b0, S_IDLE, M_ALL, 1);
    while (sb.size() != 0) begin
      start = sb[0].start; abort = sb[0].abort; result_ack = sb[0].ack;
      cycle();
      e = sb.pop_front();
      n_run++;
      if ((sample() & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL timeout step %0d: dut=%b expected=%b", step, sample(), e.val);
      end
      step++;
    end
  endtask

  task automatic test_abort();
    step_t e;
    int    step = 0;
    lat = '{2, 5, 2};
    push_run(2, 5, 0);
    // The model raises layer_done[1] on this same edge.
    push(1'b0, 1'b1, 1'b0, S_IDLE, M_ALL, 1);
    push(1'b0, 1'b0, 1'b0, S_IDLE, M_ALL, 2);
    while (sb.size() != 0) begin
      start = sb[0].start; abort = sb[0].abort; result_ack = sb[0].ack;
      cycle();
      e = sb.pop_front();
      n_run++;
      if ((sample() & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL abort step %0d: dut=%b expected=%b", step, sample(), e.val);
      end
      step++;
    end
  endtask

  task automatic test_spurious();
    step_t e;
    int    step = 0;
    model_on   = 1'b0;
    layer_done = 3'b110;
    push(1'b1, 1'b0, 1'b0, S_CLR, M_ALL, 1);
    for (int k = 0; k < TO; k++) push(logic'(k % 2), 1'b0, 1'b0, S_R0, M_ALL, 1);
    push(1'b0, 1'b0, 1'b0, S_ERR,  M_NOIDX, 1);
    push(1'b0, 1'b1, 1'b0, S_IDLE, M_ALL, 1);
    while (sb.size() != 0) begin
      start = sb[0].start; abort = sb[0].abort; result_ack = sb[0].ack;
      cycle();
      e = sb.pop_front();
      n_run++;
      if ((sample() & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL spurious step %0d: dut=%b expected=%b", step, sample(), e.val);
      end
      step++;
    end
    layer_done = '0;
    model_on   = 1'b1;
  endtask

  task automatic test_reset_in_hold();
    step_t e;
    int    step = 0;
    lat = '{1, 1, 1};
    push_run(1, 1, 1);
    push(1'b0, 1'b0, 1'b0, S_HOLD, M_NOIDX, 2);
    while (sb.size() != 0) begin
      start = sb[0].start; abort = sb[0].abort; result_ack = sb[0].ack;
      cycle();
      e = sb.pop_front();
      n_run++;
      if ((sample() & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL rst_hold step %0d: dut=%b expected=%b", step, sample(), e.val);
      end
      step++;
    end
    rst = 1'b1;
    #1;
    n_run++;
    if (sample() !== S_IDLE) begin
      n_fail++;
      $display("FAIL rst_hold_async: dut=%b expected=%b", sample(), S_IDLE);
    end
    cycle();
    rst = 1'b0;
    lat = '{2, 3, 1};
    push(1'b0, 1'b0, 1'b0, S_IDLE, M_ALL, 1);
    push_run(2, 3, 1);
    push(1'b0, 1'b0, 1'b0, S_HOLD, M_NOIDX, 1);
    push(1'b0, 1'b0, 1'b1, S_IDLE, M_ALL, 1);
    while (sb.size() != 0) begin
      start = sb[0].start; abort = sb[0].abort; result_ack = sb[0].ack;
      cycle();
      e = sb.pop_front();
      n_run++;
      if ((sample() & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL rst_rerun step %0d: dut=%b expected=%b", step, sample(), e.val);
      end
      step++;
    end
  endtask

  task automatic test_back_to_back();
    step_t e;
    int    step = 0;
    lat = '{1, 2, 1};
    push_run(1, 2, 1);
    push(1'b0, 1'b0, 1'b0, S_HOLD, M_NOIDX, 1);
    push(1'b1, 1'b0, 1'b1, S_IDLE, M_ALL, 1);
    push_run(1, 2, 1);
    push(1'b0, 1'b0, 1'b0, S_HOLD, M_NOIDX, 1);
    push(1'b0, 1'b0, 1'b1, S_IDLE, M_ALL, 1);
    while (sb.size() != 0) begin
      start = sb[0].start; abort = sb[0].abort; result_ack = sb[0].ack;
      cycle();
      e = sb.pop_front();
      n_run++;
      if ((sample() & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: dut=%b expected=%b", step, sample(), e.val);
      end
      step++;
    end
    start = 1'b0; abort = 1'b0; result_ack = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    result_ack = 1'b0;
    layer_done = '0;
    lat        = '{4, 8, 2};
    cnt        = '{0, 0, 0};
    test_reset();
    test_nominal();
    test_timeout();
    test_abort();
    test_spurious();
    test_reset_in_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
